seq_ntt_polymul: RTL and testbench
==================================

Name: seq_ntt_polymul

Overview:
- Sequential, parametrised successor to the combinational 8x8-bit naive NTT polynomial multiplier.
- Computes the cyclic convolution c = a * b mod (x^N - 1) over Z_mod using naive O(N^2) forward NTTs, a pointwise product and a naive inverse NTT.
- Uses one shared datapath: two forward MACs, one inverse MAC and one twiddle multiplier, driven by an FSM.
- Sits alongside the NTT blocks as the area-efficient polynomial multiplier, with a start/done handshake.

Parameters:
N, 8, number of coefficients per polynomial (power of two, >= 2)
W, 8, coefficient / modulus width in bits
LOGN, $clog2(N), index counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
data_a  in  N*W  polynomial a; coefficient i at bits [i*W +: W]
data_b  in  N*W  polynomial b; same packing
mod  in  W  modulus q
omega  in  W  primitive N-th root of unity mod q
inv_omega  in  W  omega^-1 mod q
inv_n  in  W  N^-1 mod q
busy  out  1  high from the start-accept edge until done
done  out  1  one-cycle pulse when result is valid
err  out  1  set with done when mod < 2; cleared on next accepted start
result  out  N*W  product coefficients, same packing; held until next accepted start

Behaviour:
- Reset (async, any state): FSM -> IDLE; busy=0, done=0, err=0, result=0; all counters and accumulators cleared.
- IDLE: start=1 captures data_a, data_b, mod, omega, inv_omega, inv_n, inv_psi/psi if enabled. Each coefficient is reduced mod q at capture. busy rises.
  - mod < 2: go to DONE directly; result=0, err=1.
  - Otherwise go to FWD with k=0, j=0, wk=1, tw=1.
- FWD (N*N cycles), one term per cycle:
  - accA += a[j]*tw, accB += b[j]*tw, each mod q.
  - tw <- tw*wk mod q.
  - At j=N-1: write A[k], B[k]; then wk <- wk*omega, k++, j=0, tw=1, accumulators cleared.
- PMUL (N cycles): C[k] = A[k]*B[k] mod q.
- INV (N*N cycles): same loop with inv_omega on C.
  - At j=N-1: result[k] = (final_acc * inv_n) mod q.
- DONE (1 cycle): done=1, busy=0; return to IDLE.
- Latency: done rises exactly 2*N*N + N + 1 edges after the start-sampling edge (137 for N=8). mod<2 case: 1 edge.
- Arithmetic: products are 2W bits, reduced with %. Modular add computes (acc+term) in W+1 bits, then subtracts q if >= q. omega, inv_omega and inv_n are not checked for consistency.
- start while busy: ignored, no queuing. start in the DONE cycle: ignored.
- Reset mid-operation aborts the operation; no done pulse is issued.

Optional Feature:
NWC_EN:
- Defined:
  - Adds inputs psi (W) and inv_psi (W), with psi^2 = omega mod q.
  - Result becomes the negacyclic product mod (x^N + 1).
  - FWD pre-twist is folded into the twiddle: wk starts at psi and steps by omega.
  - INV output is multiplied by inv_psi^k, using a running power register updated per k.
  - Latency is unchanged.
- Undefined: ports absent; cyclic product only.

Test Plan:
Common setup: N=8, W=8, mod=17, omega=2, inv_omega=9, inv_n=15.
1. a=64'h0000_0000_0000_0100 (x), b=64'h0100_0000_0000_0000 (x^7) -> result=64'h0000_0000_0000_0001; done exactly 137 cycles after start; busy high throughout.
2. a=b=64'h0000_0000_0000_0101 (1+x) -> result=64'h0000_0000_0001_0201.
3. a=64'h0000_0000_0000_0012 (coefficient 18), b=64'h0000_0000_0000_0005 -> result=64'h0000_0000_0000_0005 (input reduction).
4. mod=1, any data -> done one cycle after start, err=1, result=0. A following valid start clears err.
5. Second start pulsed mid-FWD -> ignored, result of test 1 unchanged. rst asserted mid-INV -> busy=0 and result=0 immediately; a fresh start then completes correctly.
6. NWC_EN with psi=6, inv_psi=3, inputs as test 1 -> result=64'h0000_0000_0000_0010 (x^8 = -1 = 16).

Source files
------------

// File: rtl/seq_ntt_polymul.sv
// Sequential cyclic polymul mod (x^N - 1) over Z_q via naive NTT; `define NWC_EN for negacyclic mod (x^N + 1).
// Latency: done 2*N*N + N + 1 edges after start is sampled (1 edge when mod < 2).
// No backpressure: start is accepted only in IDLE; result is held until the next accepted start.
module seq_ntt_polymul #(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int LOGN = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*W-1:0] data_a,
    input  logic [N*W-1:0] data_b,
    input  logic [W-1:0]   mod,
    input  logic [W-1:0]   omega,
    input  logic [W-1:0]   inv_omega,
    input  logic [W-1:0]   inv_n,
`ifdef NWC_EN
    input  logic [W-1:0]   psi,
    input  logic [W-1:0]   inv_psi,
`endif
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [N*W-1:0] result
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FWD  = 3'd1;
    localparam logic [2:0] S_PMUL = 3'd2;
    localparam logic [2:0] S_INV  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    function automatic logic [W-1:0] mred(input logic [2*W-1:0] x, input logic [W-1:0] q);
        logic [2*W-1:0] r;
        r = (q < W'(2)) ? '0 : x % {{W{1'b0}}, q};
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] mmul(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] q);
        return mred({{W{1'b0}}, x} * {{W{1'b0}}, y}, q);
    endfunction

    function automatic logic [W-1:0] madd(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] q);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        return s[W-1:0];
    endfunction

    logic [2:0]      state;
    logic [LOGN-1:0] k, j;
    logic [W-1:0]    a_r [N];
    logic [W-1:0]    b_r [N];
    logic [W-1:0]    fa  [N];   // A during FWD, overwritten by C = A*B in PMUL
    logic [W-1:0]    fb  [N];
    logic [W-1:0]    mod_q, om_q, iom_q, ninv_q;
    logic [W-1:0]    wk, tw, acc_a, acc_b, pw, ipsi_q;

    logic [W-1:0] src_a, sum_a, sum_b, tw_nxt, wk_nxt, pmul, out_val;

    always_comb begin
        src_a   = (state == S_INV) ? fa[j] : a_r[j];
        sum_a   = madd(acc_a, mmul(src_a, tw, mod_q), mod_q);
        sum_b   = madd(acc_b, mmul(b_r[j], tw, mod_q), mod_q);
        tw_nxt  = mmul(tw, wk, mod_q);
        wk_nxt  = mmul(wk, (state == S_INV) ? iom_q : om_q, mod_q);
        pmul    = mmul(fa[k], fb[k], mod_q);
        // pw stays 1 in the cyclic build, so the extra multiply is an identity there
        out_val = mmul(mmul(sum_a, ninv_q, mod_q), pw, mod_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            k      <= '0;
            j      <= '0;
            mod_q  <= '0;
            om_q   <= '0;
            iom_q  <= '0;
            ninv_q <= '0;
            ipsi_q <= '0;
            wk     <= '0;
            tw     <= '0;
            pw     <= '0;
            acc_a  <= '0;
            acc_b  <= '0;
            for (int i = 0; i < N; i++) begin
                a_r[i] <= '0;
                b_r[i] <= '0;
                fa[i]  <= '0;
                fb[i]  <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    for (int i = 0; i < N; i++) begin
                        a_r[i] <= mred({{W{1'b0}}, data_a[i*W +: W]}, mod);
                        b_r[i] <= mred({{W{1'b0}}, data_b[i*W +: W]}, mod);
                    end
                    mod_q  <= mod;
                    om_q   <= omega;
                    iom_q  <= inv_omega;
                    ninv_q <= inv_n;
`ifdef NWC_EN
                    wk     <= psi;
                    ipsi_q <= inv_psi;
`else
                    wk     <= W'(1);
                    ipsi_q <= W'(1);
`endif
                    tw     <= W'(1);
                    pw     <= W'(1);
                    acc_a  <= '0;
                    acc_b  <= '0;
                    k      <= '0;
                    j      <= '0;
                    busy   <= 1'b1;
                    err    <= 1'b0;
                    result <= '0;
                    state  <= (mod < W'(2)) ? S_DONE : S_FWD;
                end
                S_FWD: begin
                    if (j == LAST) begin
                        fa[k] <= sum_a;
                        fb[k] <= sum_b;
                        acc_a <= '0;
                        acc_b <= '0;
                        tw    <= W'(1);
                        wk    <= wk_nxt;
                        j     <= '0;
                        k     <= k + 1'b1;
                        if (k == LAST) state <= S_PMUL;
                    end else begin
                        acc_a <= sum_a;
                        acc_b <= sum_b;
                        tw    <= tw_nxt;
                        j     <= j + 1'b1;
                    end
                end
                S_PMUL: begin
                    fa[k] <= pmul;
                    k     <= k + 1'b1;
                    if (k == LAST) begin
                        wk    <= W'(1);
                        tw    <= W'(1);
                        j     <= '0;
                        state <= S_INV;
                    end
                end
                S_INV: begin
                    if (j == LAST) begin
                        result[int'(k)*W +: W] <= out_val;
                        pw    <= mmul(pw, ipsi_q, mod_q);
                        acc_a <= '0;
                        tw    <= W'(1);
                        wk    <= wk_nxt;
                        j     <= '0;
                        k     <= k + 1'b1;
                        if (k == LAST) state <= S_DONE;
                    end else begin
                        acc_a <= sum_a;
                        tw    <= tw_nxt;
                        j     <= j + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    err   <= (mod_q < W'(2));
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_ntt_polymul.sv
// Scoreboard bench for seq_ntt_polymul: directed vectors queued at start, checked on each done pulse.
module tb_seq_ntt_polymul;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [63:0] data_a, data_b;
    logic [7:0]  mod, omega, inv_omega, inv_n;
    logic        busy, done, err;
    logic [63:0] result;
`ifdef NWC_EN
    logic [7:0]  psi, inv_psi;
`endif

    seq_ntt_polymul #(.N(8), .W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .data_a(data_a), .data_b(data_b),
        .mod(mod), .omega(omega), .inv_omega(inv_omega), .inv_n(inv_n),
`ifdef NWC_EN
        .psi(psi), .inv_psi(inv_psi),
`endif
        .busy(busy), .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

`ifdef NWC_EN
    localparam logic [63:0] E_X8 = 64'h0000_0000_0000_0010;
`else
    localparam logic [63:0] E_X8 = 64'h0000_0000_0000_0001;
`endif
    localparam logic [63:0] X1  = 64'h0000_0000_0000_0100;
    localparam logic [63:0] X7  = 64'h0100_0000_0000_0000;
    localparam logic [63:0] P11 = 64'h0000_0000_0000_0101;
    localparam logic [63:0] E_SQ = 64'h0000_0000_0001_0201;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            if (sbq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 with result %h, expected no done", result);
            end else begin
                e = sbq.pop_front();
                check("result", result, e.res);
                check("err_at_done", {63'b0, err}, {63'b0, e.err});
                check("busy_at_done", {63'b0, busy}, 64'd0);
            end
        end
    end

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [7:0] q,
                          input logic [63:0] exp_res, input logic exp_err, input int exp_lat,
                          input int ghost_at, input int abort_at, input string tag);
        int   cnt;
        int   gaps;
        bit   aborted;
        exp_t e;
        @(negedge clk);
        data_a = a;
        data_b = b;
        mod    = q;
        start  = 1'b1;
        if (abort_at < 0) begin
            e.res = exp_res;
            e.err = exp_err;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        gaps = 0;
        aborted = 1'b0;
        check({tag, "_busy_on_accept"}, {63'b0, busy}, 64'd1);
        check({tag, "_err_cleared"}, {63'b0, err}, 64'd0);
        while (done !== 1'b1 && cnt < 400) begin
            if (busy !== 1'b1) gaps++;
            if (cnt == ghost_at + 1) start = 1'b0;
            if (cnt == ghost_at) begin
                start  = 1'b1;
                data_a = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            if (cnt == abort_at) begin
                rst = 1'b1;
                #1;
                check({tag, "_abort_busy"}, {63'b0, busy}, 64'd0);
                check({tag, "_abort_result"}, result, 64'd0);
                check({tag, "_abort_done"}, {63'b0, done}, 64'd0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            cnt++;
        end
        if (!aborted) begin
            check({tag, "_latency"}, 64'(cnt), 64'(exp_lat));
            check({tag, "_busy_gaps"}, 64'(gaps), 64'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        data_a    = '0;
        data_b    = '0;
        mod       = 8'd17;
        omega     = 8'd2;
        inv_omega = 8'd9;
        inv_n     = 8'd15;
`ifdef NWC_EN
        psi       = 8'd6;
        inv_psi   = 8'd3;
`endif
        #12;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_err", {63'b0, err}, 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(X1, X7, 8'd17, E_X8, 1'b0, 137, -1, -1, "t1");
        repeat (3) @(negedge clk);
        check("t1_result_held", result, E_X8);

        run_op(P11, P11, 8'd17, E_SQ, 1'b0, 137, -1, -1, "t2");
        run_op(64'h12, 64'h05, 8'd17, 64'h05, 1'b0, 137, -1, -1, "t3");
        run_op(64'h1234_5678_9ABC_DEF0, P11, 8'd1, 64'd0, 1'b1, 1, -1, -1, "t4");
        repeat (2) @(negedge clk);
        check("t4_err_held", {63'b0, err}, 64'd1);
        run_op(P11, P11, 8'd17, E_SQ, 1'b0, 137, -1, -1, "t4b");

        run_op(X1, X7, 8'd17, E_X8, 1'b0, 137, 10, -1, "t5a");
        run_op(P11, P11, 8'd17, E_SQ, 1'b0, 137, -1, 100, "t5b");
        repeat (3) @(negedge clk);
        run_op(X1, X7, 8'd17, E_X8, 1'b0, 137, -1, -1, "t5c");

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
